processor: RTL and testbench

//  Single-cycle RV32I-subset CPU core. Fetches one instruction per clock from an external

---
 rtl/processor.sv | 163 ++++++++++++++++
 tb/tb_processor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/processor.sv
// rtl/processor.sv - single-cycle RV32I-subset core with external instruction/data memories
// Decode, ALU and memory access are combinational; pc and register file update on posedge.
module processor #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        write_enable,
    output logic [31:0] address_to_mem,
    output logic [31:0] data_to_mem,
    input  logic [31:0] data_from_mem
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [0:31];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] alu_b, alu_y, rd_wdata;
    logic        alu_ok, br_taken, rd_we, store;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'h0 : regs_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'h0 : regs_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    // For OP-IMM, funct7 only qualifies shifts; elsewhere those bits are immediate.
    always_comb begin
        alu_b  = (opcode == OP_R) ? rs2_val : imm_i;
        alu_ok = 1'b1;
        alu_y  = 32'h0;
        case (funct3)
            3'b000: begin
                if (opcode == OP_R && funct7 == 7'h20) alu_y = rs1_val - alu_b;
                else if (opcode == OP_I || funct7 == 7'h00) alu_y = rs1_val + alu_b;
                else alu_ok = 1'b0;
            end
            3'b001: begin
                if (funct7 == 7'h00) alu_y = rs1_val << alu_b[4:0];
                else alu_ok = 1'b0;
            end
            3'b010: begin
                if (opcode == OP_I || funct7 == 7'h00)
                    alu_y = {31'h0, $signed(rs1_val) < $signed(alu_b)};
                else alu_ok = 1'b0;
            end
            3'b100: begin
                if (opcode == OP_I || funct7 == 7'h00) alu_y = rs1_val ^ alu_b;
                else alu_ok = 1'b0;
            end
            3'b101: begin
                if (funct7 == 7'h00) alu_y = rs1_val >> alu_b[4:0];
                else if (funct7 == 7'h20) alu_y = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
                else alu_ok = 1'b0;
            end
            3'b110: begin
                if (opcode == OP_I || funct7 == 7'h00) alu_y = rs1_val | alu_b;
                else alu_ok = 1'b0;
            end
            3'b111: begin
                if (opcode == OP_I || funct7 == 7'h00) alu_y = rs1_val & alu_b;
                else alu_ok = 1'b0;
            end
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d     = pc_plus4;
        rd_we    = 1'b0;
        rd_wdata = 32'h0;
        store    = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                rd_we    = alu_ok;
                rd_wdata = alu_y;
            end
            OP_LOAD: begin
                rd_we    = (funct3 == 3'b010);
                rd_wdata = data_from_mem;
            end
            OP_STORE: store = (funct3 == 3'b010);
            OP_BR:    if (br_taken) pc_d = pc_q + imm_b;
            OP_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OP_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OP_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = pc_q + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we    = 1'b1;
                    rd_wdata = pc_plus4;
                    pc_d     = (rs1_val + imm_i) & 32'hFFFF_FFFE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            for (int k = 0; k < 32; k++) regs_q[k] <= 32'h0;
        end else begin
            pc_q <= pc_d;
            if (rd_we && rd != 5'd0) regs_q[rd] <= rd_wdata;
        end
    end

    assign pc             = pc_q;
    assign write_enable   = reset & store;
    assign address_to_mem = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign data_to_mem    = rs2_val;

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - directed program bench for the single-cycle core
module tb_processor;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        write_enable;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic [31:0] imem [0:127];
    int          checks;
    int          errors;

    processor #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .instruction    (instruction),
        .write_enable   (write_enable),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .data_from_mem  (data_from_mem)
    );

    assign instruction = imem[pc[8:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [31:0] exp_pc);
        @(negedge clk);
        check_eq($sformatf("pc@%0h", exp_pc), pc, exp_pc);
    endtask

    task automatic expect_store(input logic [31:0] addr, input logic [31:0] data);
        check_eq($sformatf("we@%0h", pc), {31'h0, write_enable}, 32'h1);
        check_eq($sformatf("addr@%0h", pc), address_to_mem, addr);
        check_eq($sformatf("data@%0h", pc), data_to_mem, data);
    endtask

    task automatic expect_no_store();
        check_eq($sformatf("we0@%0h", pc), {31'h0, write_enable}, 32'h0);
    endtask

    localparam logic [6:0] OPI = 7'b0010011;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        data_from_mem = 32'hDEADBEEF;
        for (int k = 0; k < 128; k++) imem[k] = 32'h0;
        imem[0]  = enc_i(5, 0, 3'b000, 1, OPI);
        imem[1]  = enc_i(7, 0, 3'b000, 2, OPI);
        imem[2]  = enc_r(7'h00, 2, 1, 3'b000, 3);
        imem[3]  = enc_s(4, 3, 0);
        imem[4]  = enc_b(8, 0, 0, 3'b000);
        imem[5]  = enc_i(1, 0, 3'b000, 9, OPI);
        imem[6]  = enc_b(8, 0, 0, 3'b001);
        imem[7]  = enc_i(4, 0, 3'b010, 4, 7'b0000011);
        imem[8]  = enc_j(16, 1);
        imem[9]  = enc_s(8, 4, 0);
        imem[10] = enc_i(32'h40, 0, 3'b000, 1, OPI);
        imem[11] = enc_i(9, 0, 3'b000, 0, OPI);
        imem[12] = enc_s(12, 1, 0);
        imem[13] = enc_i(0, 1, 3'b000, 0, 7'b1100111);
        imem[16] = enc_u(20'h00001, 6, 7'b0010111);
        imem[17] = enc_u(20'h12345, 5, 7'b0110111);
        imem[18] = enc_s(0, 0, 0);
        imem[19] = enc_s(16, 6, 0);
        imem[20] = enc_s(20, 5, 0);
        imem[21] = enc_i(-1, 0, 3'b000, 5, OPI);
        imem[22] = enc_i(1, 0, 3'b000, 6, OPI);
        imem[23] = enc_b(8, 6, 5, 3'b100);
        imem[24] = enc_i(1, 0, 3'b000, 9, OPI);
        imem[25] = enc_i(-8, 0, 3'b000, 7, OPI);
        imem[26] = enc_i(32'h401, 7, 3'b101, 8, OPI);
        imem[27] = enc_s(24, 8, 0);
        imem[28] = enc_i(1, 7, 3'b101, 8, OPI);
        imem[29] = enc_s(28, 8, 0);
        imem[30] = enc_b(8, 6, 5, 3'b101);
        imem[31] = enc_r(7'h20, 5, 6, 3'b000, 9);
        imem[32] = enc_r(7'h00, 6, 5, 3'b010, 10);
        imem[33] = enc_s(32, 9, 0);
        imem[34] = enc_s(36, 10, 0);
        imem[36] = enc_s(40, 3, 0);

        repeat (3) @(negedge clk);
        check_eq("rst_pc", pc, 32'h0);
        expect_no_store();
        reset = 1'b1;
        check_eq("pc@0", pc, 32'h0);
        tick(32'h04);
        tick(32'h08);
        tick(32'h0C); expect_store(32'h4, 32'd12);
        tick(32'h10);
        tick(32'h18);
        tick(32'h1C); expect_no_store(); check_eq("lw_addr", address_to_mem, 32'h4);
        tick(32'h20);
        tick(32'h30); expect_store(32'hC, 32'h24);
        tick(32'h34);
        tick(32'h24); expect_store(32'h8, 32'hDEADBEEF);
        tick(32'h28);
        tick(32'h2C);
        tick(32'h30); expect_store(32'hC, 32'h40);
        tick(32'h34);
        tick(32'h40);
        tick(32'h44);
        tick(32'h48); expect_store(32'h0, 32'h0);
        tick(32'h4C); expect_store(32'h10, 32'h1040);
        tick(32'h50); expect_store(32'h14, 32'h12345000);
        tick(32'h54);
        tick(32'h58);
        tick(32'h5C);
        tick(32'h64);
        tick(32'h68);
        tick(32'h6C); expect_store(32'h18, 32'hFFFFFFFC);
        tick(32'h70);
        tick(32'h74); expect_store(32'h1C, 32'h7FFFFFFC);
        tick(32'h78);
        tick(32'h7C);
        tick(32'h80);
        tick(32'h84); expect_store(32'h20, 32'h2);
        tick(32'h88); expect_store(32'h24, 32'h1);
        tick(32'h8C); expect_no_store();
        tick(32'h90); expect_store(32'h28, 32'd12);
        tick(32'h94);

        #2 reset = 1'b0;
        imem[0] = enc_s(0, 4, 0);
        imem[1] = enc_s(4, 3, 0);
        imem[2] = enc_s(8, 1, 0);
        #1;
        check_eq("async_rst_pc", pc, 32'h0);
        expect_no_store();
        @(negedge clk);
        check_eq("held_rst_pc", pc, 32'h0);
        expect_no_store();
        reset = 1'b1;
        #1 expect_store(32'h0, 32'h0);
        tick(32'h04); expect_store(32'h4, 32'h0);
        tick(32'h08); expect_store(32'h8, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
